// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Definitions shared by the fetch-stage controller and its PC/NPC register
// pair: the controller state encoding, the sequential PC increment and the
// default reset address.
// ---------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_pair.sv
// ---------------------------------------------------------------------------
// fetch_pc_pair
// PC/NPC register pair of the fetch stage. On a load edge PC takes NPC, and
// NPC takes either the (word-aligned) redirect target or NPC + 4.
//
// Ports:
//   clk       pipeline clock
//   reset     asynchronous, active-low
//   load      fetch completion; advance the pair this edge
//   tgt_vld   a redirect target replaces the sequential NPC
//   tgt_addr  redirect target; bits [1:0] are discarded
//   pc        address of the instruction being fetched
//   npc       address of the next instruction
// ---------------------------------------------------------------------------
module fetch_pc_pair
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        tgt_vld,
  input  logic [31:0] tgt_addr,
  output logic [31:0] pc,
  output logic [31:0] npc
);

  localparam logic [31:0] RESET_NPC = RESET_PC + PC_INC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Plain 32-bit add: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  function automatic logic [31:0] seq_next(input logic [31:0] addr);
    return addr + PC_INC;
  endfunction

  // Only NPC is redirected, so the instruction at the current NPC (the delay
  // slot) is still fetched before the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      npc <= RESET_NPC;
    end else if (load) begin
      pc  <= npc;
      npc <= tgt_vld ? word_align(tgt_addr) : seq_next(npc);
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Fetch-stage controller: sequences instruction-memory requests, honours
// hazard stalls, applies branch/jump redirects with delay-slot semantics and
// raises a sticky error when memory stops answering.
//
// Ports:
//   clk              pipeline clock
//   reset            asynchronous, active-low
//   stall_in         hazard stall; blocks fetch completion
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  redirect address (bits [1:0] ignored)
//   imem_ready       memory data valid for imem_addr this cycle
//   imem_req         fetch request (FETCH state)
//   imem_addr        fetch address (= pc_out)
//   pc_out, npc_out  current / next PC
//   if_id_load       IF/ID register captures the instruction at this edge
//   fetch_count      completed fetches, wraps modulo 2^32
//   timeout_err      sticky memory-timeout flag
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        if_id_load,
  output logic [31:0] fetch_count,
  output logic        timeout_err
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT - 1;

  fetch_state_e state_q, state_d;
  logic         pend_vld_p0;
  logic [31:0]  pend_tgt_p0;
  logic [31:0]  wait_cnt_p0;
  logic [31:0]  fetch_cnt_p0;
  logic         waiting;
  logic         sel_vld;
  logic [31:0]  sel_tgt;
  logic         redir_take;

  // Next state and request/complete decode
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    if_id_load = 1'b0;
    waiting    = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req   = 1'b1;
        if_id_load = imem_ready && !stall_in;
        // Ready together with stall is not a wait: memory re-presents data.
        waiting    = !imem_ready && !stall_in;
        if (TO_EN && waiting && (wait_cnt_p0 == TO_LAST)) begin
          state_d = ERROR;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = BOOT;
    endcase
  end

  // Redirects are remembered until the next completion; ERROR drops them.
  assign redir_take = redirect_valid && (state_q != ERROR) && !if_id_load;
  assign sel_vld    = redirect_valid || pend_vld_p0;
  assign sel_tgt    = redirect_valid ? redirect_target : pend_tgt_p0;

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pend_vld_p0  <= 1'b0;
      wait_cnt_p0  <= '0;
      fetch_cnt_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (if_id_load) begin
        pend_vld_p0  <= 1'b0;
        wait_cnt_p0  <= '0;
        fetch_cnt_p0 <= fetch_cnt_p0 + 32'd1;
      end else begin
        if (redir_take) pend_vld_p0 <= 1'b1;
        if (waiting)    wait_cnt_p0 <= wait_cnt_p0 + 32'd1;
      end
    end
  end

  // Pending target is only meaningful while pend_vld_p0 is set.
  always_ff @(posedge clk) begin
    if (redir_take) pend_tgt_p0 <= redirect_target;
  end

  fetch_pc_pair #(
    .RESET_PC (RESET_PC)
  ) u_pc_pair (
    .clk      (clk),
    .reset    (reset),
    .load     (if_id_load),
    .tgt_vld  (sel_vld),
    .tgt_addr (sel_tgt),
    .pc       (pc_out),
    .npc      (npc_out)
  );

  assign imem_addr   = pc_out;
  assign fetch_count = fetch_cnt_p0;
  assign timeout_err = (state_q == ERROR);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: RESET_PC = 0, TIMEOUT = 4
  logic        reset, stall_in, redirect_valid, imem_ready;
  logic [31:0] redirect_target;
  logic        imem_req, if_id_load, timeout_err;
  logic [31:0] imem_addr, pc_out, npc_out, fetch_count;

  // Second DUT: RESET_PC = FFFF_FFF8, TIMEOUT = 0 (disabled)
  logic        h_reset, h_ready;
  logic        h_zero = 1'b0;
  logic [31:0] h_tgt  = 32'h0;
  logic        h_req, h_load, h_err;
  logic [31:0] h_addr, h_pc, h_npc, h_count;

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc_out(pc_out), .npc_out(npc_out), .if_id_load(if_id_load),
    .fetch_count(fetch_count), .timeout_err(timeout_err)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .TIMEOUT(0)) u_hi (
    .clk(clk), .reset(h_reset), .stall_in(h_zero),
    .redirect_valid(h_zero), .redirect_target(h_tgt),
    .imem_ready(h_ready), .imem_req(h_req), .imem_addr(h_addr),
    .pc_out(h_pc), .npc_out(h_npc), .if_id_load(h_load),
    .fetch_count(h_count), .timeout_err(h_err)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every IF/ID load must match the next expected fetch.
  always @(negedge clk) begin
    if (if_id_load) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: got load at %h expected no load", imem_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        chk32("fetch_addr", imem_addr, mon_exp);
      end
    end
  end

  initial begin
    reset = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; imem_ready = 1'b1;
    h_reset = 1'b0; h_ready = 1'b1;
    repeat (2) cyc();

    // Reset state
    chk32("rst_pc", pc_out, 32'h0);
    chk32("rst_npc", npc_out, 32'h4);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_load", if_id_load, 1'b0);
    chk32("rst_count", fetch_count, 32'h0);
    chk1("rst_err", timeout_err, 1'b0);

    // Release: one BOOT cycle, then zero-wait sequential fetch
    reset = 1'b1; #1;
    chk1("boot_req", imem_req, 1'b0);
    cyc();
    chk1("first_req", imem_req, 1'b1);
    chk32("pc_0", pc_out, 32'h0);
    exp_q.push_back(32'h0);
    cyc();
    chk32("pc_4", pc_out, 32'h4);
    exp_q.push_back(32'h4);
    cyc();
    chk32("pc_8", pc_out, 32'h8);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    exp_q.push_back(32'h8);
    cyc();
    redirect_valid = 1'b0;
    chk32("pc_slot", pc_out, 32'hC);
    chk32("npc_redir", npc_out, 32'h100);
    exp_q.push_back(32'hC);
    cyc();
    chk32("pc_target", pc_out, 32'h100);
    chk32("count_4", fetch_count, 32'd4);
    exp_q.push_back(32'h100);
    cyc();
    chk32("pc_104", pc_out, 32'h104);
    chk32("npc_108", npc_out, 32'h108);

    // Three wait cycles with a redirect pulse (unaligned target) in the middle
    imem_ready = 1'b0; #1;
    chk1("wait_load_0", if_id_load, 1'b0);
    cyc();
    redirect_valid = 1'b1; redirect_target = 32'h43; #1;
    chk1("wait_load_1", if_id_load, 1'b0);
    cyc();
    redirect_valid = 1'b0; #1;
    chk1("wait_load_2", if_id_load, 1'b0);
    chk32("wait_addr", imem_addr, 32'h104);
    cyc();
    imem_ready = 1'b1;
    exp_q.push_back(32'h104);
    cyc();
    chk32("pc_after_wait", pc_out, 32'h108);
    chk32("npc_pending", npc_out, 32'h40);

    // Stall with ready high: nothing moves, no error
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("stall_load", if_id_load, 1'b0);
      chk32("stall_addr", imem_addr, 32'h108);
      cyc();
    end
    chk1("stall_err", timeout_err, 1'b0);
    chk32("stall_npc", npc_out, 32'h40);
    stall_in = 1'b0;
    exp_q.push_back(32'h108);
    cyc();
    chk32("pc_40", pc_out, 32'h40);
    exp_q.push_back(32'h40);
    cyc();
    chk32("pc_44", pc_out, 32'h44);
    chk32("npc_48", npc_out, 32'h48);

    // Timeout: 2 waits, 3 stalled cycles (counter holds), 2 more waits
    imem_ready = 1'b0;
    cyc();
    cyc();
    stall_in = 1'b1;
    repeat (3) cyc();
    chk1("err_held_by_stall", timeout_err, 1'b0);
    stall_in = 1'b0;
    cyc();
    chk1("err_before_limit", timeout_err, 1'b0);
    chk1("req_before_limit", imem_req, 1'b1);
    cyc();
    chk1("err_at_limit", timeout_err, 1'b1);
    chk1("req_in_error", imem_req, 1'b0);
    chk32("count_8", fetch_count, 32'd8);
    imem_ready = 1'b1; #1;
    chk1("load_in_error", if_id_load, 1'b0);
    repeat (3) cyc();
    chk1("err_sticky", timeout_err, 1'b1);
    chk32("pc_frozen", pc_out, 32'h44);

    // Asynchronous reset out of ERROR
    reset = 1'b0; #1;
    chk1("async_err", timeout_err, 1'b0);
    chk1("async_req", imem_req, 1'b0);
    chk32("async_pc", pc_out, 32'h0);
    chk32("async_count", fetch_count, 32'h0);

    // Redirect during BOOT is held pending
    cyc();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    chk32("boot_pc", pc_out, 32'h0);
    exp_q.push_back(32'h0);
    cyc();
    chk32("boot_redir_pc", pc_out, 32'h4);
    chk32("boot_redir_npc", npc_out, 32'h80);

    // Reset mid-request drops a pending redirect
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
    cyc();
    redirect_valid = 1'b0;
    reset = 1'b0; #1;
    chk1("midreset_req", imem_req, 1'b0);
    cyc();
    reset = 1'b1; imem_ready = 1'b1;
    cyc();
    exp_q.push_back(32'h0);
    cyc();
    chk32("midreset_pc", pc_out, 32'h4);
    chk32("midreset_npc", npc_out, 32'h8);
    imem_ready = 1'b0;
    cyc();
    chk32("queue_drained", exp_q.size(), 32'd0);

    // High reset address wraps; TIMEOUT=0 never errors
    h_reset = 1'b1;
    cyc();
    chk32("hi_addr_0", h_addr, 32'hFFFF_FFF8);
    cyc();
    chk32("hi_pc_1", h_pc, 32'hFFFF_FFFC);
    cyc();
    chk32("hi_pc_wrap", h_pc, 32'h0000_0000);
    chk32("hi_npc_wrap", h_npc, 32'h0000_0004);
    chk32("hi_count", h_count, 32'd2);
    h_ready = 1'b0;
    repeat (20) cyc();
    chk1("hi_no_timeout", h_err, 1'b0);
    chk1("hi_req", h_req, 1'b1);
    chk1("hi_load", h_load, 1'b0);
    chk32("hi_pc_held", h_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage controller for the pipelined MIPS core. Owns the PC/NPC pair, sequences instruction-memory requests with a ready handshake, and honours hazard-unit stalls. Applies branch/jump redirects with MIPS delay-slot semantics and tells the IF/ID register when to load. Sits between the hazard/branch logic in ID and the IF-stage instruction register.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; low 2 bits must be 0
- TIMEOUT, 16, consecutive unanswered request cycles before error; 0 disables timeout
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting forces reset state immediately
- stall_in  in  1  hazard-unit stall; blocks fetch completion
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  redirect address; bits [1:0] ignored, forced to 00
- imem_ready  in  1  instruction memory data valid for imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc_out
- pc_out  out  32  address of instruction being fetched
- npc_out  out  32  next PC
- if_id_load  out  1  IF/ID register captures instruction at this edge
- fetch_count  out  32  completed fetches, wraps modulo 2^32
- timeout_err  out  1  sticky memory-timeout flag

## Operation
- States: BOOT, FETCH, ERROR. Reset -> BOOT; BOOT -> FETCH after one cycle; FETCH -> ERROR on timeout; ERROR held until reset.
- imem_req = (state == FETCH). imem_addr = pc_out.
- Completion: if_id_load = FETCH & imem_ready & !stall_in (combinational).
- On completion edge: pc_out <= npc_out; npc_out <= redirect_target (if redirect_valid) else pending target (if pending) else npc_out + 4; pending cleared; fetch_count += 1; wait counter cleared.
- Delay slot: redirect overwrites NPC only, so the instruction at the current npc_out (the slot) is still fetched before the target.
- Redirect without completion: latched into pending register (valid + target); a later redirect before completion overwrites it (newest wins).
- Redirect in BOOT is latched as pending; in ERROR it is ignored.
- Wait counter: increments in FETCH when !imem_ready & !stall_in; holds while stall_in=1; on reaching TIMEOUT (TIMEOUT≠0) -> ERROR, timeout_err=1, imem_req=0, if_id_load=0.
- Arithmetic: npc_out + 4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- stall_in and imem_ready both high: no completion; address held stable; memory must re-present data next cycle.

## Timing
- Reset values: pc_out=RESET_PC, npc_out=RESET_PC+4, imem_req=0, if_id_load=0, fetch_count=0, timeout_err=0, pending cleared, wait counter 0, state BOOT.
- First imem_req on the 2nd rising edge after reset deasserts (BOOT lasts one cycle).
- Zero-wait memory: one completion per cycle, pc_out advances every edge.
- imem_addr changes only on a completion edge or reset.
- Reset mid-request: request dropped immediately, pending redirect and counter lost.

## Structure
- Shared package if_pkg: state enum (BOOT, FETCH, ERROR), PC_INC=4, default RESET_PC.
- One sub-module natural: fetch_pc_pair (PC/NPC registers with load, redirect mux and +4 adder); FSM, pending latch and counters in the top.

## Test plan
- Reset release, imem_ready=1 constant -> pc_out 0,4,8,C on successive edges; fetch_count=4 after four completions.
- redirect_valid with target 32'h100 while pc_out=8 -> next pc_out C (delay slot), then 100, 104.
- imem_ready low 3 cycles with redirect pulse during wait (target 32'h40) -> no if_id_load for 3 cycles; after completion npc_out=40.
- stall_in high 5 cycles with imem_ready=1 -> pc_out, imem_addr stable, if_id_load=0, wait counter not incremented, no timeout.
- TIMEOUT=4, imem_ready held 0 -> ERROR after 4 waiting cycles: timeout_err=1, imem_req=0; stays until reset asserted.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000.
